// File: rtl/memtile_long_delay_drain.sv
// memtile_long_delay_drain
//   Read-side drain for a memtile run as a long circular delay line.
//   Discards the first DELAY valid words, which are read from uninitialised
//   SRAM. Forwards FRAME_WORDS words through a small FIFO to a ready/valid
//   consumer and tags each word with end-of-line and end-of-frame markers.
//
// Ports
//   clk        : single clock
//   flush      : synchronous active-high reset; restarts the frame
//   in_data    : memtile rdata
//   in_valid   : memtile valid_out
//   out_data   : forwarded word
//   out_valid  : out_data is valid
//   out_ready  : consumer accepts the word
//   out_eol    : current word is the last word of a line
//   out_eof    : current word is the last word of the frame
//   frame_done : level; FRAME_WORDS words have been accepted or dropped
//   overflow   : sticky; a STREAM word was dropped on a full FIFO
//   drop_count : (MEMTILE_DRAIN_DROPCNT_EN only) saturating count of drops
//
// Optional feature macro: MEMTILE_DRAIN_DROPCNT_EN
module memtile_long_delay_drain #(
  parameter int DATA_WIDTH  = 16,
  parameter int DELAY       = 1919,
  parameter int LINE_WIDTH  = 1920,
  parameter int FRAME_WORDS = 2073600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  frame_done,
`ifdef MEMTILE_DRAIN_DROPCNT_EN
  output logic [15:0]           drop_count,
`endif
  output logic                  overflow
);

  localparam int SW   = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam int WW   = $clog2(FRAME_WORDS + 1);
  localparam int CW   = $clog2(LINE_WIDTH + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = $clog2(FIFO_DEPTH + 1);
  localparam int EW   = DATA_WIDTH + 2;

  typedef enum logic [1:0] {WARMUP, STREAM, DONE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   skip_cnt;
  logic [WW-1:0]   word_cnt;
  logic [CW-1:0]   col_cnt;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count;

  logic            push_req, push, pop, full, drop;
  logic            eol_in, eof_in, skip_last;

  assign skip_last = (skip_cnt == SW'(DELAY - 1));

  // state register
  always_ff @(posedge clk) begin
    if (flush) state <= (DELAY == 0) ? STREAM : WARMUP;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      WARMUP:  if (in_valid && skip_last) state_nxt = STREAM;
      STREAM:  if (in_valid && eof_in)    state_nxt = DONE;
      default: state_nxt = state;
    endcase
  end

  // output / datapath control
  always_comb begin
    push_req   = (state == STREAM) && in_valid;
    eol_in     = (col_cnt == CW'(LINE_WIDTH - 1));
    eof_in     = (word_cnt == WW'(FRAME_WORDS - 1));
    frame_done = (state == DONE);
  end

  assign full      = (count == NW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  // framing counters; word_cnt advances on dropped words too
  always_ff @(posedge clk) begin
    if (flush) begin
      skip_cnt <= '0;
      word_cnt <= '0;
      col_cnt  <= '0;
    end else begin
      if (state == WARMUP && in_valid) skip_cnt <= skip_cnt + 1'b1;
      if (push_req) begin
        word_cnt <= word_cnt + 1'b1;
        col_cnt  <= eol_in ? '0 : col_cnt + 1'b1;
      end
    end
  end

  // FIFO storage; head entry drives the outputs directly
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_data, eol_in, eof_in};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign out_data = mem[rd_ptr][EW-1:2];
  assign out_eol  = mem[rd_ptr][1];
  assign out_eof  = mem[rd_ptr][0];

  always_ff @(posedge clk) begin
    if (flush)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef MEMTILE_DRAIN_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (flush)                        drop_count <= '0;
    else if (drop && drop_count != '1) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule
